// File: rtl/chacha_block_sched.sv
// ---------------------------------------------------------------------------
// chacha_block_sched
//
// Keystream block scheduler for the ChaCha20 datapath. Accepts a job (first
// 32-bit block counter plus block count) and drives the ChaCha20 block core
// one block at a time: start pulse with the block counter, wait for the core,
// then hold the block until downstream takes it. Tracks the number of blocks
// handed off in the current job and, optionally, refuses to let the block
// counter wrap inside one job.
//
// Configuration macro:
//   CHACHA_OVF_CHECK_EN  defined   -> counter-wrap check active, ERR state and
//                                     sticky ovf_err present.
//                        undefined -> counter wraps modulo 2^32, ovf_err = 0.
//
// Parameters:
//   GAP             idle cycles between a block handshake and the next
//                   core_start (0..15).
//
// Ports:
//   clk             clock, rising edge
//   init_n          synchronous active-low reset
//   job_valid/ready job request handshake (ready only in IDLE)
//   job_ctr0        first block counter of the job
//   job_nblocks     number of blocks in the job
//   core_start      one-cycle start pulse to the core
//   core_ctr        block counter for the core, stable start..done
//   core_done       one-cycle pulse from the core, block ready
//   blk_valid/ready block handoff to downstream
//   blocksproduced  blocks handed off in the current job
//   job_done        one-cycle pulse when a job completes
//   ovf_err         sticky counter-overflow error
// ---------------------------------------------------------------------------
module chacha_block_sched #(
  parameter int GAP = 0
) (
  input  logic        clk,
  input  logic        init_n,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [31:0] job_ctr0,
  input  logic [31:0] job_nblocks,
  output logic        core_start,
  output logic [31:0] core_ctr,
  input  logic        core_done,
  output logic        blk_valid,
  input  logic        blk_ready,
  output logic [31:0] blocksproduced,
  output logic        job_done,
  output logic        ovf_err
);

  // The gap counter is loaded with GAP-1 so that GAPW lasts exactly GAP cycles.
  localparam bit         HAS_GAP  = (GAP > 0);
  localparam logic [3:0] GAP_LOAD = HAS_GAP ? 4'(GAP - 1) : 4'd0;

`ifdef CHACHA_OVF_CHECK_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_WAIT, ST_HOLD, ST_GAPW, ST_ERR
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_WAIT, ST_HOLD, ST_GAPW
  } state_t;
`endif

  state_t      state_reg, state_next;
  logic [31:0] ctr_reg, ctr_next;
  logic [31:0] rem_reg, rem_next;
  logic [31:0] bp_reg, bp_next;
  logic [3:0]  gap_cnt_reg, gap_cnt_next;
  logic        job_done_reg, job_done_next;
`ifdef CHACHA_OVF_CHECK_EN
  logic        ovf_reg, ovf_next;
`endif

  always_ff @(posedge clk) begin
    if (!init_n) begin
      state_reg    <= ST_IDLE;
      ctr_reg      <= 32'd0;
      rem_reg      <= 32'd0;
      bp_reg       <= 32'd0;
      gap_cnt_reg  <= 4'd0;
      job_done_reg <= 1'b0;
`ifdef CHACHA_OVF_CHECK_EN
      ovf_reg      <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      ctr_reg      <= ctr_next;
      rem_reg      <= rem_next;
      bp_reg       <= bp_next;
      gap_cnt_reg  <= gap_cnt_next;
      job_done_reg <= job_done_next;
`ifdef CHACHA_OVF_CHECK_EN
      ovf_reg      <= ovf_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    ctr_next      = ctr_reg;
    rem_next      = rem_reg;
    bp_next       = bp_reg;
    gap_cnt_next  = gap_cnt_reg;
    job_done_next = 1'b0;
`ifdef CHACHA_OVF_CHECK_EN
    ovf_next      = ovf_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        if (job_valid) begin
          ctr_next = job_ctr0;
          rem_next = job_nblocks;
          bp_next  = 32'd0;
`ifdef CHACHA_OVF_CHECK_EN
          ovf_next = 1'b0;
`endif
          // An empty job completes immediately without touching the core.
          if (job_nblocks == 32'd0) begin
            job_done_next = 1'b1;
          end else begin
            state_next = ST_START;
          end
        end
      end

      ST_START: begin
        state_next = ST_WAIT;
      end

      ST_WAIT: begin
        if (core_done) begin
          state_next = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (blk_ready) begin
          bp_next  = bp_reg + 32'd1;
          rem_next = rem_reg - 32'd1;
          if (rem_reg == 32'd1) begin
            // Last block: finishing at counter FFFFFFFF is legal.
            job_done_next = 1'b1;
            state_next    = ST_IDLE;
          end
`ifdef CHACHA_OVF_CHECK_EN
          else if (ctr_reg == 32'hFFFF_FFFF) begin
            ovf_next   = 1'b1;
            state_next = ST_ERR;
          end
`endif
          else begin
            ctr_next = ctr_reg + 32'd1;
            if (HAS_GAP) begin
              gap_cnt_next = GAP_LOAD;
              state_next   = ST_GAPW;
            end else begin
              state_next = ST_START;
            end
          end
        end
      end

      ST_GAPW: begin
        if (gap_cnt_reg == 4'd0) begin
          state_next = ST_START;
        end else begin
          gap_cnt_next = gap_cnt_reg - 4'd1;
        end
      end

`ifdef CHACHA_OVF_CHECK_EN
      // Terminal until init_n.
      ST_ERR: begin
        state_next = ST_ERR;
      end
`endif

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign job_ready      = (state_reg == ST_IDLE);
  assign core_start     = (state_reg == ST_START);
  assign blk_valid      = (state_reg == ST_HOLD);
  assign core_ctr       = ctr_reg;
  assign blocksproduced = bp_reg;
  assign job_done       = job_done_reg;
`ifdef CHACHA_OVF_CHECK_EN
  assign ovf_err        = ovf_reg;
`else
  assign ovf_err        = 1'b0;
`endif

endmodule

// File: tb/tb_chacha_block_sched.sv
// ---------------------------------------------------------------------------
// tb_chacha_block_sched
//
// Directed bench for chacha_block_sched (GAP = 0). Inputs are driven and
// outputs sampled on the falling edge; the DUT acts on the rising edge.
// Expected values for the overflow job follow CHACHA_OVF_CHECK_EN.
// ---------------------------------------------------------------------------
module tb_chacha_block_sched;

  logic        clk;
  logic        init_n;
  logic        job_valid;
  logic        job_ready;
  logic [31:0] job_ctr0;
  logic [31:0] job_nblocks;
  logic        core_start;
  logic [31:0] core_ctr;
  logic        core_done;
  logic        blk_valid;
  logic        blk_ready;
  logic [31:0] blocksproduced;
  logic        job_done;
  logic        ovf_err;

  int checks = 0;
  int errors = 0;

  chacha_block_sched #(.GAP(0)) dut (
    .clk            (clk),
    .init_n         (init_n),
    .job_valid      (job_valid),
    .job_ready      (job_ready),
    .job_ctr0       (job_ctr0),
    .job_nblocks    (job_nblocks),
    .core_start     (core_start),
    .core_ctr       (core_ctr),
    .core_done      (core_done),
    .blk_valid      (blk_valid),
    .blk_ready      (blk_ready),
    .blocksproduced (blocksproduced),
    .job_done       (job_done),
    .ovf_err        (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  // Present a job for one cycle; returns at the falling edge of the cycle
  // after acceptance (START for a non-empty job).
  task automatic submit(input logic [31:0] ctr0, input logic [31:0] n);
    job_valid   = 1'b1;
    job_ctr0    = ctr0;
    job_nblocks = n;
    @(negedge clk);
    job_valid   = 1'b0;
    job_ctr0    = 32'hDEAD_BEEF;
    job_nblocks = 32'h0000_0055;
  endtask

  // Entered at the falling edge of a START cycle with blk_ready=1. Core answers
  // 4 cycles after its start pulse. Returns one cycle after the handshake.
  task automatic do_block(input logic [31:0] exp_ctr, input logic [31:0] exp_bp);
    check("start_pulse", 32'(core_start), 32'd1);
    check("start_ctr", core_ctr, exp_ctr);
    @(negedge clk);
    check("start_one_cycle", 32'(core_start), 32'd0);
    repeat (3) @(negedge clk);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    check("hold_valid", 32'(blk_valid), 32'd1);
    check("hold_ctr", core_ctr, exp_ctr);
    @(negedge clk);
    check("blocksproduced", blocksproduced, exp_bp);
  endtask

  task automatic pulse_reset();
    init_n = 1'b0;
    @(negedge clk);
    init_n = 1'b1;
  endtask

  initial begin
    init_n      = 1'b0;
    job_valid   = 1'b0;
    job_ctr0    = 32'd0;
    job_nblocks = 32'd0;
    core_done   = 1'b0;
    blk_ready   = 1'b1;
    repeat (2) @(negedge clk);
    init_n = 1'b1;

    // Reset state
    check("rst_job_ready", 32'(job_ready), 32'd1);
    check("rst_core_start", 32'(core_start), 32'd0);
    check("rst_core_ctr", core_ctr, 32'd0);
    check("rst_blk_valid", 32'(blk_valid), 32'd0);
    check("rst_bp", blocksproduced, 32'd0);
    check("rst_job_done", 32'(job_done), 32'd0);
    check("rst_ovf_err", 32'(ovf_err), 32'd0);

    // Basic job: 0,1,2
    submit(32'd0, 32'd3);
    for (int i = 0; i < 3; i++) begin
      do_block(32'(i), 32'(i + 1));
      if (i < 2) begin
        check("basic_job_done_low", 32'(job_done), 32'd0);
      end
    end
    check("basic_job_done", 32'(job_done), 32'd1);
    check("basic_job_ready", 32'(job_ready), 32'd1);
    check("basic_no_restart", 32'(core_start), 32'd0);
    @(negedge clk);
    check("basic_done_one_pulse", 32'(job_done), 32'd0);

    // Backpressure, plus a stray job request that must be ignored
    blk_ready = 1'b0;
    submit(32'd100, 32'd2);
    check("bp_start_ctr", core_ctr, 32'd100);
    repeat (4) @(negedge clk);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    job_valid = 1'b1;
    job_ctr0  = 32'd7;
    job_nblocks = 32'd0;
    for (int i = 0; i < 10; i++) begin
      check("bp_valid_held", 32'(blk_valid), 32'd1);
      check("bp_no_start", 32'(core_start), 32'd0);
      check("bp_count_held", blocksproduced, 32'd0);
      @(negedge clk);
    end
    job_valid = 1'b0;
    blk_ready = 1'b1;
    @(negedge clk);
    check("bp_count_after", blocksproduced, 32'd1);
    do_block(32'd101, 32'd2);
    check("bp_job_done", 32'(job_done), 32'd1);

    // Zero-length job
    @(negedge clk);
    submit(32'd50, 32'd0);
    check("zero_job_done", 32'(job_done), 32'd1);
    check("zero_no_start", 32'(core_start), 32'd0);
    check("zero_job_ready", 32'(job_ready), 32'd1);
    @(negedge clk);
    check("zero_done_one_pulse", 32'(job_done), 32'd0);
    check("zero_still_no_start", 32'(core_start), 32'd0);

    // Final block at FFFFFFFF is legal
    submit(32'hFFFF_FFFD, 32'd3);
    do_block(32'hFFFF_FFFD, 32'd1);
    do_block(32'hFFFF_FFFE, 32'd2);
    do_block(32'hFFFF_FFFF, 32'd3);
    check("edge_job_done", 32'(job_done), 32'd1);
    check("edge_ovf_err", 32'(ovf_err), 32'd0);

    // Four blocks across the wrap point
    @(negedge clk);
    submit(32'hFFFF_FFFD, 32'd4);
    do_block(32'hFFFF_FFFD, 32'd1);
    do_block(32'hFFFF_FFFE, 32'd2);
    do_block(32'hFFFF_FFFF, 32'd3);
`ifdef CHACHA_OVF_CHECK_EN
    check("ovf_err_set", 32'(ovf_err), 32'd1);
    check("ovf_job_ready", 32'(job_ready), 32'd0);
    check("ovf_no_done", 32'(job_done), 32'd0);
    check("ovf_no_start", 32'(core_start), 32'd0);
    repeat (3) @(negedge clk);
    check("ovf_err_sticky", 32'(ovf_err), 32'd1);
    check("ovf_bp", blocksproduced, 32'd3);
    check("ovf_no_done_later", 32'(job_done), 32'd0);
`else
    check("wrap_no_done", 32'(job_done), 32'd0);
    do_block(32'h0000_0000, 32'd4);
    check("wrap_job_done", 32'(job_done), 32'd1);
    check("wrap_ovf_err", 32'(ovf_err), 32'd0);
`endif
    pulse_reset();
    check("post_ovf_ovf_err", 32'(ovf_err), 32'd0);
    check("post_ovf_job_ready", 32'(job_ready), 32'd1);
    check("post_ovf_bp", blocksproduced, 32'd0);

    // Reset in WAIT of the second block, then a stray core_done
    submit(32'd5, 32'd3);
    do_block(32'd5, 32'd1);
    @(negedge clk);
    init_n = 1'b0;
    @(negedge clk);
    init_n    = 1'b1;
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("mid_rst_blk_valid", 32'(blk_valid), 32'd0);
      check("mid_rst_bp", blocksproduced, 32'd0);
      check("mid_rst_core_start", 32'(core_start), 32'd0);
      @(negedge clk);
    end
    check("mid_rst_core_ctr", core_ctr, 32'd0);
    check("mid_rst_job_ready", 32'(job_ready), 32'd1);
    check("mid_rst_job_done", 32'(job_done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
